// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load/branch/mul-div stalls,
// IF/ID flush control and a fixed-latency mul/div occupancy tracker.
module pipe_hazard_ctrl #(
   parameter int unsigned MD_LAT = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic       JumpD,
   input  logic       MdOpD,
   input  logic       MdStartE,
   output logic       StallF,
   output logic       EnD,
   output logic       ClrD,
   output logic       FlushE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MdBusy,
   output logic       MdDone
);

   localparam int unsigned CNT_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   md_state_t          state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               done_q, done_nxt;

   logic m_wr, w_wr, e_wr, m_ld;
   logic lwstall, brstall, mdstall, stall;

   // Mul/div occupancy state register; reset aborts any operation in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   // Next state: a start while busy is ignored
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (MdStartE) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_W'(MD_LAT - 1);
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign MdBusy = (state == BUSY);
   assign MdDone = done_q;

   // Writers that can supply a value; register 0 is never forwarded
   assign m_wr = RegWriteM && (WriteRegM != '0);
   assign w_wr = RegWriteW && (WriteRegW != '0);
   assign e_wr = RegWriteE && (WriteRegE != '0);
   assign m_ld = MemtoRegM && (WriteRegM != '0);

   assign lwstall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
   assign brstall = BranchD &&
                    ((e_wr && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                     (m_ld && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   assign mdstall = MdOpD && ((state == BUSY) || MdStartE);
   assign stall   = RST && (lwstall || brstall || mdstall);

   // Hazard outputs are forced to their quiet values while reset is held
   always_comb begin
      StallF    = stall;
      EnD       = !stall;
      FlushE    = stall;
      ClrD      = RST && (PCSrcD || JumpD) && !stall;
      ForwardAD = RST && m_wr && (WriteRegM == RsD);
      ForwardBD = RST && m_wr && (WriteRegM == RtD);
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RST) begin
         if (m_wr && (WriteRegM == RsE))      ForwardAE = 2'b10;
         else if (w_wr && (WriteRegW == RsE)) ForwardAE = 2'b01;
         if (m_wr && (WriteRegM == RtE))      ForwardBE = 2'b10;
         else if (w_wr && (WriteRegW == RtE)) ForwardBE = 2'b01;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LAT = 8).
module tb_pipe_hazard_ctrl;

   logic       CLK, RST;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, JumpD, MdOpD, MdStartE;
   logic       StallF, EnD, ClrD, FlushE, ForwardAD, ForwardBD, MdBusy, MdDone;
   logic [1:0] ForwardAE, ForwardBE;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.MD_LAT(8)) dut (
      .CLK(CLK), .RST(RST),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
      .MdOpD(MdOpD), .MdStartE(MdStartE),
      .StallF(StallF), .EnD(EnD), .ClrD(ClrD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MdBusy(MdBusy), .MdDone(MdDone)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; PCSrcD = 0; JumpD = 0; MdOpD = 0; MdStartE = 0;
   endtask

   // Inputs change on the falling edge; outputs are sampled 2 units later
   task automatic next_cycle();
      @(negedge CLK);
   endtask

   // Starting with MdStartE already seen in cycle 0: busy 1..8, done in 9 only
   task automatic md_run(input string tag, input int restart_at);
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         MdStartE = (k == restart_at);
         #2;
         check({tag, "_busy"}, 32'(MdBusy), 32'(k <= 8));
         check({tag, "_done"}, 32'(MdDone), 32'(k == 9));
         check({tag, "_stall"}, 32'(StallF), 32'(MdOpD && (k <= 8)));
      end
   endtask

   initial begin
      clear_inputs();
      RST = 1'b0;
      // Hazard inputs present during reset must not leak through
      MemtoRegE = 1; RtE = 5; RsD = 5;
      RegWriteM = 1; WriteRegM = 8; RsE = 8; PCSrcD = 1;
      #2;
      check("rst_stallf", 32'(StallF), 0);
      check("rst_end",    32'(EnD), 1);
      check("rst_clrd",   32'(ClrD), 0);
      check("rst_flushe", 32'(FlushE), 0);
      check("rst_fwdae",  32'(ForwardAE), 0);
      check("rst_fwdad",  32'(ForwardAD), 0);
      check("rst_busy",   32'(MdBusy), 0);
      check("rst_done",   32'(MdDone), 0);

      next_cycle();
      clear_inputs();
      RST = 1'b1;
      next_cycle();

      // Forwarding priority: memory stage beats writeback
      RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8; RtE = 3;
      #2;
      check("fwd_ae_mem", 32'(ForwardAE), 2'b10);
      check("fwd_be_none", 32'(ForwardBE), 2'b00);
      WriteRegM = 0;
      #2;
      check("fwd_ae_wb_r0m", 32'(ForwardAE), 2'b01);
      RegWriteW = 0;
      #2;
      check("fwd_ae_none", 32'(ForwardAE), 2'b00);
      RegWriteW = 1; WriteRegM = 7; RtE = 8;
      #2;
      check("fwd_be_wb", 32'(ForwardBE), 2'b01);
      RegWriteM = 1; WriteRegM = 8; RegWriteW = 0;
      #2;
      check("fwd_be_mem", 32'(ForwardBE), 2'b10);
      RegWriteM = 0;
      #2;
      check("fwd_be_nowr", 32'(ForwardBE), 2'b00);

      // Decode comparator forwarding
      clear_inputs();
      RegWriteM = 1; WriteRegM = 4; RsD = 4; RtD = 6;
      #2;
      check("fwd_ad", 32'(ForwardAD), 1);
      check("fwd_bd_no", 32'(ForwardBD), 0);
      RtD = 4;
      #2;
      check("fwd_bd", 32'(ForwardBD), 1);
      WriteRegM = 0; RsD = 0; RtD = 0;
      #2;
      check("fwd_ad_r0", 32'(ForwardAD), 0);

      // Load-use stall
      next_cycle();
      clear_inputs();
      MemtoRegE = 1; RtE = 5; RsD = 5;
      #2;
      check("lw_stallf", 32'(StallF), 1);
      check("lw_end",    32'(EnD), 0);
      check("lw_flushe", 32'(FlushE), 1);
      RsD = 1; RtD = 5;
      #2;
      check("lw_rtd_stall", 32'(StallF), 1);
      next_cycle();
      RtE = 0; RsD = 0; RtD = 0;
      #2;
      check("lw_r0_stallf", 32'(StallF), 0);
      check("lw_r0_end",    32'(EnD), 1);
      check("lw_r0_flushe", 32'(FlushE), 0);

      // Branch stall suppresses the IF/ID clear, then the clear fires
      next_cycle();
      clear_inputs();
      BranchD = 1; PCSrcD = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9;
      #2;
      check("br_stall", 32'(StallF), 1);
      check("br_clrd_held", 32'(ClrD), 0);
      next_cycle();
      RegWriteE = 0;
      #2;
      check("br_clrd", 32'(ClrD), 1);
      check("br_end",  32'(EnD), 1);
      MemtoRegM = 1; WriteRegM = 9;
      #2;
      check("br_ldm_stall", 32'(StallF), 1);
      next_cycle();
      clear_inputs();
      JumpD = 1;
      #2;
      check("jmp_clrd", 32'(ClrD), 1);
      check("jmp_stall", 32'(StallF), 0);

      // Mul/div: MdStartE in cycle 0 with MdOpD held throughout
      next_cycle();
      clear_inputs();
      MdOpD = 1; MdStartE = 1;
      #2;
      check("md_c0_stall", 32'(StallF), 1);
      check("md_c0_busy",  32'(MdBusy), 0);
      md_run("md", 0);

      // Start while busy is ignored; latency unchanged
      next_cycle();
      MdOpD = 0; MdStartE = 1;
      #2;
      check("mdv_c0_stall", 32'(StallF), 0);
      md_run("mdv", 3);

      // Reset in the third busy cycle aborts with no done pulse
      next_cycle();
      MdStartE = 1;
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         MdStartE = 0;
      end
      #2;
      check("abort_pre_busy", 32'(MdBusy), 1);
      RST = 1'b0;
      #1;
      check("abort_busy", 32'(MdBusy), 0);
      check("abort_done", 32'(MdDone), 0);
      next_cycle();
      #2;
      check("abort_hold_done", 32'(MdDone), 0);
      RST = 1'b1;
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         #2;
         check("abort_idle_busy", 32'(MdBusy), 0);
         check("abort_idle_done", 32'(MdDone), 0);
      end

      // Full-length operation after release
      next_cycle();
      MdOpD = 1; MdStartE = 1;
      #2;
      check("post_c0_stall", 32'(StallF), 1);
      md_run("post", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 8, the multiply/divide latency in cycles; legal range 2..31.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports RsD, RtD, RsE, RtE, input, 5 bits each: source register numbers in decode and execute.
REQ-005 SHALL have ports WriteRegE, WriteRegM, WriteRegW, input, 5 bits each: destination register numbers in execute, memory and writeback.
REQ-006 SHALL have ports RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, input, 1 bit each: writeback-enable and load flags per stage.
REQ-007 SHALL have ports BranchD, PCSrcD, JumpD, input, 1 bit each: branch in decode, branch taken, and jump in decode.
REQ-008 SHALL have ports MdOpD and MdStartE, input, 1 bit each: decode instruction uses the mul/div unit or HI/LO; mul/div operation starting in execute.
REQ-009 SHALL have ports StallF, EnD, ClrD and FlushE, output, 1 bit each: PC hold, IF/ID register enable, IF/ID register clear, and ID/EX register clear.
REQ-010 SHALL have ports ForwardAD and ForwardBD, output, 1 bit each: decode comparator operand select (1 = memory-stage result).
REQ-011 SHALL have ports ForwardAE and ForwardBE, output, 2 bits each: ALU operand select (00 = register file, 10 = memory stage, 01 = writeback stage).
REQ-012 SHALL have ports MdBusy and MdDone, output, 1 bit each, both registered: mul/div unit occupied; one-cycle completion pulse.

Function
REQ-013 ForwardAE SHALL be 10 when RegWriteM=1, WriteRegM!=0 and WriteRegM==RsE; otherwise 01 when RegWriteW=1, WriteRegW!=0 and WriteRegW==RsE; otherwise 00. ForwardBE SHALL use the same rule with RtE.
REQ-014 ForwardAD SHALL be RegWriteM && WriteRegM!=0 && WriteRegM==RsD; ForwardBD SHALL use the same rule with RtD.
REQ-015 lwstall SHALL be MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
REQ-016 brstall SHALL be BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
REQ-017 mdstall SHALL be MdOpD && (state==BUSY || MdStartE).
REQ-018 Stall SHALL be lwstall | brstall | mdstall; StallF SHALL equal Stall, EnD SHALL equal !Stall, and FlushE SHALL equal Stall.
REQ-019 ClrD SHALL be (PCSrcD | JumpD) && !Stall; a stall suppresses the flush, because the IF/ID clear takes priority over its enable.
REQ-020 The mul/div FSM SHALL have two states, IDLE and BUSY, with a 5-bit down-counter.
REQ-021 In IDLE with MdStartE=1, the FSM SHALL go to BUSY next cycle with counter=MD_LAT-1.
REQ-022 In BUSY with counter!=0, the counter SHALL decrement by 1 per cycle.
REQ-023 In BUSY with counter==0, the FSM SHALL return to IDLE and MdDone SHALL be 1 for exactly that following cycle.
REQ-024 MdBusy SHALL be 1 exactly while in BUSY; BUSY SHALL last MD_LAT cycles.
REQ-025 MdStartE=1 while BUSY is a protocol violation; it SHALL be ignored, with no restart and no counter change.
REQ-026 A mul/div op entering execute while the FSM is finishing (counter==0) SHALL be held by mdstall until IDLE, so back-to-back ops are separated by at least one IDLE cycle.

Reset
REQ-027 While RST=0, the FSM SHALL be IDLE, counter=0 and MdBusy=MdDone=0, independent of CLK.
REQ-028 While RST=0, StallF=0, EnD=1, ClrD=0, FlushE=0 and all Forward* outputs SHALL be 0.
REQ-029 Reset asserted mid-BUSY SHALL abort the operation with no MdDone pulse; after release the FSM SHALL be IDLE.

Verification
REQ-030 RegWriteM=1, WriteRegM=8, RsE=8, and RegWriteW=1, WriteRegW=8 -> ForwardAE=10 (memory stage wins); with WriteRegM=0 -> ForwardAE=01.
REQ-031 MemtoRegE=1, RtE=5, RsD=5 -> StallF=1, EnD=0, FlushE=1 for one cycle; with RtE=0 -> no stall.
REQ-032 BranchD=1, PCSrcD=1, RegWriteE=1, WriteRegE=RtD=9 -> Stall=1, ClrD=0; next cycle with no hazard -> ClrD=1, EnD=1.
REQ-033 MD_LAT=8, MdStartE pulse at cycle 0 -> MdBusy=1 in cycles 1..8, MdDone=1 in cycle 9 only; MdOpD=1 throughout -> Stall=1 in cycles 0..8, 0 in cycle 9.
REQ-034 Start a mul/div op, assert RST=0 at BUSY cycle 3 -> MdBusy drops immediately, no MdDone pulse; after release a new MdStartE gives a full MD_LAT busy period.
